gemm_sched: RTL and testbench
=============================

GEMM_SCHED -- requirements
Module: gemm_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one GEMM engine.
REQ-002 SHALL have parameter TAG_WIDTH, default 4, width of the per-job tag.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum run cycles before a job is aborted.
REQ-004 SHALL have port iclk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port irst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ireq_valid  input  NUM_REQ  per-requester job request.
REQ-007 SHALL have port ireq_tag  input  NUM_REQ x TAG_WIDTH  per-requester job tag.
REQ-008 SHALL have port oreq_ready  output  NUM_REQ  one-hot job-accept strobe.
REQ-009 SHALL have port ostart  output  1  one-cycle start pulse to engine.
REQ-010 SHALL have port idone  input  1  engine completion pulse.
REQ-011 SHALL have port osel  output  clog2(NUM_REQ)  index of requester owning the engine (operand mux select).
REQ-012 SHALL have ports ocpl_valid (1), ocpl_id (clog2(NUM_REQ)), ocpl_tag (TAG_WIDTH), ocpl_timeout (1), all outputs: completion report.
REQ-013 SHALL have port ostray_cnt  output  8  saturating count of idone pulses outside RUN.
REQ-014 SHALL have port oidle  output  1  high in IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> LAUNCH -> RUN -> COMPLETE -> IDLE; DONE-style states are not skipped.
REQ-016 IDLE: when any ireq_valid is high, SHALL grant one requester by round-robin, assert oreq_ready[grant] combinationally that cycle, latch grant and tag, and go to LAUNCH.
REQ-017 Round-robin SHALL search from rr_ptr upward with wrap; after a grant rr_ptr SHALL become (grant+1) mod NUM_REQ.
REQ-018 LAUNCH SHALL last exactly one cycle with ostart=1; ostart SHALL be 0 in all other states.
REQ-019 RUN SHALL count cycles from 1; on idone go to COMPLETE with timeout flag 0; on count reaching TIMEOUT_CYCLES without idone go to COMPLETE with timeout flag 1.
REQ-020 idone and timeout in the same cycle SHALL resolve as normal completion (ocpl_timeout=0).
REQ-021 COMPLETE SHALL last one cycle with ocpl_valid=1, ocpl_id=latched grant, ocpl_tag=latched tag, ocpl_timeout=flag; no backpressure.
REQ-022 osel SHALL hold the latched grant from LAUNCH through COMPLETE inclusive.
REQ-023 Latency: request accepted cycle N -> ostart at N+1 -> RUN from N+2; idone at cycle M -> ocpl_valid at M+1 -> IDLE at M+2, new grant possible at M+2.
REQ-024 idone in IDLE, LAUNCH or COMPLETE SHALL be ignored for sequencing and increment ostray_cnt, saturating at 255.
REQ-025 oreq_ready SHALL be all-zero outside IDLE; a requester dropping ireq_valid before grant SHALL not be granted.

Reset
REQ-026 On irst: state=IDLE, rr_ptr=0, run counter=0, ostart=0, ocpl_valid=0, ocpl_id=0, ocpl_tag=0, ocpl_timeout=0, osel=0, ostray_cnt=0, oidle=1.
REQ-027 Reset mid-job SHALL discard the job with no completion report; reset dominates all other inputs in that cycle.

Structure
REQ-028 Shared package gemm_pkg SHALL hold the sched state enum (IDLE, LAUNCH, RUN, COMPLETE) and default NUM_REQ/TAG_WIDTH constants.
REQ-029 Round-robin grant logic SHALL be a sub-module gemm_rr_arbiter (inputs req vector, ptr; output one-hot grant, index, any).

Verification
REQ-030 All four ireq_valid held high, idone 5 cycles after each ostart -> grants in order 0,1,2,3,0; ocpl_id matches each.
REQ-031 Requester 2 only, tag 0xA, idone at cycle 3 of RUN -> ostart one cycle after ready, ocpl_valid next cycle with id=2, tag=0xA, timeout=0.
REQ-032 TIMEOUT_CYCLES=8, no idone -> ocpl_valid one cycle after run count 8, ocpl_timeout=1, back to IDLE.
REQ-033 idone on exactly the 8th run cycle with TIMEOUT_CYCLES=8 -> ocpl_timeout=0.
REQ-034 irst asserted during RUN -> no ocpl_valid, outputs at reset values next cycle, next grant from requester 0.
REQ-035 300 idone pulses while IDLE -> ostray_cnt=255, no ostart or ocpl_valid.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM job scheduler.
// Holds the scheduler state encoding, default sizing constants and a helper
// that gives a safe index width for a requester count.
package gemm_pkg;

  localparam int unsigned GEMM_NUM_REQ        = 4;
  localparam int unsigned GEMM_TAG_WIDTH      = 4;
  localparam int unsigned GEMM_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    RUN      = 2'd2,
    COMPLETE = 2'd3
  } sched_state_e;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemm_rr_arbiter.sv
// Round-robin arbiter for the GEMM scheduler.
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index the search starts from (highest priority this cycle)
//   gnt  - one-hot grant
//   idx  - binary index of the granted requester
//   any  - at least one request is present
// Purely combinational; the owner of ptr advances it after a grant.
module gemm_rr_arbiter
  import gemm_pkg::*;
#(
  parameter  int unsigned NUM_REQ = GEMM_NUM_REQ,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned cand;

  // Scan from ptr upward with wrap; the first asserted request wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr) + off) % NUM_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/gemm_sched.sv
// GEMM engine job scheduler.
// Shares one GEMM engine among NUM_REQ requesters: grants jobs round-robin,
// pulses the engine start, waits for completion or a run-time timeout and
// emits a one-cycle completion report.
// Ports:
//   iclk, irst    - clock, synchronous active-high reset
//   ireq_valid    - per-requester job request
//   ireq_tag      - per-requester job tag, requester i at [i*TAG_WIDTH +: TAG_WIDTH]
//   oreq_ready    - one-hot accept strobe, combinational, IDLE only
//   ostart        - one-cycle engine start pulse (LAUNCH)
//   idone         - engine completion pulse
//   osel          - requester currently owning the engine
//   ocpl_*        - completion report (valid, id, tag, timeout flag)
//   ostray_cnt    - saturating count of idone pulses seen outside RUN
//   oidle         - scheduler is in IDLE
module gemm_sched
  import gemm_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = GEMM_NUM_REQ,
  parameter  int unsigned TAG_WIDTH      = GEMM_TAG_WIDTH,
  parameter  int unsigned TIMEOUT_CYCLES = GEMM_TIMEOUT_CYCLES,
  localparam int unsigned IDX_W          = idx_width(NUM_REQ)
) (
  input  logic                           iclk,
  input  logic                           irst,
  input  logic [NUM_REQ-1:0]             ireq_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]   ireq_tag,
  output logic [NUM_REQ-1:0]             oreq_ready,
  output logic                           ostart,
  input  logic                           idone,
  output logic [IDX_W-1:0]               osel,
  output logic                           ocpl_valid,
  output logic [IDX_W-1:0]               ocpl_id,
  output logic [TAG_WIDTH-1:0]           ocpl_tag,
  output logic                           ocpl_timeout,
  output logic [7:0]                     ostray_cnt,
  output logic                           oidle
);

  // Room for the terminal count plus one so the increment never wraps early.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  sched_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       grant_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [CNT_W-1:0]       run_cnt_q;
  logic                   accept_c;
  logic                   cpl_c;
  logic                   cpl_to_c;

  gemm_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (ireq_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // State register.
  always_ff @(posedge iclk) begin
    if (irst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and combinational strobes; reset suppresses any grant.
  always_comb begin
    state_d    = state_q;
    oreq_ready = '0;
    accept_c   = 1'b0;
    cpl_c      = 1'b0;
    cpl_to_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any && !irst) begin
          oreq_ready = arb_gnt;
          accept_c   = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: state_d = RUN;
      RUN: begin
        // A done pulse on the terminal cycle wins over the timeout.
        if (idone) begin
          cpl_c   = 1'b1;
          state_d = COMPLETE;
        end else if (run_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          cpl_c    = 1'b1;
          cpl_to_c = 1'b1;
          state_d  = COMPLETE;
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Job bookkeeping, run counter and registered outputs.
  always_ff @(posedge iclk) begin
    if (irst) begin
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      tag_q        <= '0;
      run_cnt_q    <= '0;
      ostart       <= 1'b0;
      ocpl_valid   <= 1'b0;
      ocpl_id      <= '0;
      ocpl_tag     <= '0;
      ocpl_timeout <= 1'b0;
      ostray_cnt   <= '0;
      oidle        <= 1'b1;
    end else begin
      if (accept_c) begin
        grant_q  <= arb_idx;
        tag_q    <= ireq_tag[32'(arb_idx)*TAG_WIDTH +: TAG_WIDTH];
        rr_ptr_q <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
      end

      // First RUN cycle sees a count of 1.
      if (state_q == LAUNCH)   run_cnt_q <= CNT_W'(1);
      else if (state_q == RUN) run_cnt_q <= run_cnt_q + CNT_W'(1);
      else                     run_cnt_q <= '0;

      ostart     <= (state_d == LAUNCH);
      oidle      <= (state_d == IDLE);
      ocpl_valid <= cpl_c;
      if (cpl_c) begin
        ocpl_id      <= grant_q;
        ocpl_tag     <= tag_q;
        ocpl_timeout <= cpl_to_c;
      end

      if (idone && (state_q != RUN) && (ostray_cnt != 8'hFF))
        ostray_cnt <= ostray_cnt + 8'd1;
    end
  end

  assign osel = grant_q;

endmodule

// File: tb/tb_gemm_sched.sv
// Self-checking bench for gemm_sched: scoreboard of expected completion
// reports pushed at grant time and popped when ocpl_valid appears.
module tb_gemm_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TW   = 4;
  localparam int unsigned TMO  = 8;

  logic                 iclk = 1'b0;
  logic                 irst;
  logic [NREQ-1:0]      ireq_valid;
  logic [NREQ*TW-1:0]   ireq_tag;
  logic [NREQ-1:0]      oreq_ready;
  logic                 ostart;
  logic                 idone;
  logic [1:0]           osel;
  logic                 ocpl_valid;
  logic [1:0]           ocpl_id;
  logic [TW-1:0]        ocpl_tag;
  logic                 ocpl_timeout;
  logic [7:0]           ostray_cnt;
  logic                 oidle;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] tag;
    logic       to;
  } cpl_t;

  cpl_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  gemm_sched #(
    .NUM_REQ        (NREQ),
    .TAG_WIDTH      (TW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .iclk         (iclk),
    .irst         (irst),
    .ireq_valid   (ireq_valid),
    .ireq_tag     (ireq_tag),
    .oreq_ready   (oreq_ready),
    .ostart       (ostart),
    .idone        (idone),
    .osel         (osel),
    .ocpl_valid   (ocpl_valid),
    .ocpl_id      (ocpl_id),
    .ocpl_tag     (ocpl_tag),
    .ocpl_timeout (ocpl_timeout),
    .ostray_cnt   (ostray_cnt),
    .oidle        (oidle)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Called at a negedge in IDLE with requests already driven. done_at is the
  // RUN cycle (1-based) on which idone is pulsed; 0 means let it time out.
  task automatic do_job(input int exp_id, input int done_at);
    cpl_t e;
    bit   seen;
    int   lat;
    #1;
    check("ready_grant", 32'(oreq_ready), 32'(1) << exp_id);
    e.id  = 2'(exp_id);
    e.tag = ireq_tag[exp_id*4 +: 4];
    e.to  = (done_at == 0);
    exp_q.push_back(e);
    @(negedge iclk);
    check("launch_start", 32'(ostart), 32'd1);
    check("launch_sel", 32'(osel), 32'(exp_id));
    check("launch_ready", 32'(oreq_ready), 32'd0);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= int'(TMO) + 4 && !seen; c++) begin
      @(negedge iclk);
      idone = 1'b0;
      if (ocpl_valid) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        if (c == 1) check("run_start_low", 32'(ostart), 32'd0);
        if (c == done_at) idone = 1'b1;
      end
    end
    check("cpl_latency", 32'(lat), (done_at == 0) ? 32'(TMO + 1) : 32'(done_at + 1));
    if (seen) begin
      e = exp_q.pop_front();
      check("cpl_id", 32'(ocpl_id), 32'(e.id));
      check("cpl_tag", 32'(ocpl_tag), 32'(e.tag));
      check("cpl_timeout", 32'(ocpl_timeout), 32'(e.to));
      check("cpl_sel", 32'(osel), 32'(e.id));
    end
    @(negedge iclk);
    check("back_idle", 32'(oidle), 32'd1);
    check("cpl_one_cycle", 32'(ocpl_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bad_start;
    bit bad_cpl;
    irst       = 1'b1;
    ireq_valid = '0;
    ireq_tag   = '0;
    idone      = 1'b0;
    repeat (3) @(negedge iclk);
    check("rst_start", 32'(ostart), 32'd0);
    check("rst_cpl_valid", 32'(ocpl_valid), 32'd0);
    check("rst_cpl_id", 32'(ocpl_id), 32'd0);
    check("rst_cpl_tag", 32'(ocpl_tag), 32'd0);
    check("rst_cpl_to", 32'(ocpl_timeout), 32'd0);
    check("rst_sel", 32'(osel), 32'd0);
    check("rst_stray", 32'(ostray_cnt), 32'd0);
    check("rst_idle", 32'(oidle), 32'd1);
    check("rst_ready", 32'(oreq_ready), 32'd0);
    irst = 1'b0;

    // All four requesting: strict rotation 0,1,2,3,0.
    ireq_tag   = 16'h4321;
    ireq_valid = 4'hF;
    do_job(0, 5);
    do_job(1, 5);
    do_job(2, 5);
    do_job(3, 5);
    do_job(0, 5);

    // Single requester 2, tag 0xA, done on RUN cycle 3 (pointer at 1).
    ireq_valid = 4'b0100;
    ireq_tag   = 16'h0A00;
    do_job(2, 3);

    // Requester 1 alone, no done: timeout after 8 run cycles (pointer at 3, wraps).
    ireq_valid = 4'b0010;
    ireq_tag   = 16'h0050;
    do_job(1, 0);

    // Done on the terminal run cycle resolves as normal completion.
    ireq_valid = 4'b1000;
    ireq_tag   = 16'h7000;
    do_job(3, 8);

    // Sparse requests: pointer 0 picks 0, then pointer 1 skips to 3.
    ireq_valid = 4'b1001;
    ireq_tag   = 16'hC00B;
    do_job(0, 2);
    do_job(3, 1);

    // Request withdrawn before the clock edge is never granted.
    ireq_valid = 4'b0001;
    #1;
    check("drop_ready_seen", 32'(oreq_ready), 32'd1);
    #2;
    ireq_valid = 4'b0000;
    @(negedge iclk);
    check("drop_no_start", 32'(ostart), 32'd0);
    check("drop_still_idle", 32'(oidle), 32'd1);

    // Reset in the middle of RUN discards the job.
    ireq_valid = 4'b0100;
    ireq_tag   = 16'h0300;
    #1;
    check("rr_ready", 32'(oreq_ready), 32'b0100);
    repeat (3) @(negedge iclk);
    irst       = 1'b1;
    idone      = 1'b1;
    ireq_valid = 4'hF;
    #1;
    check("rst_blocks_ready", 32'(oreq_ready), 32'd0);
    @(negedge iclk);
    check("midrst_cpl", 32'(ocpl_valid), 32'd0);
    check("midrst_start", 32'(ostart), 32'd0);
    check("midrst_idle", 32'(oidle), 32'd1);
    check("midrst_sel", 32'(osel), 32'd0);
    check("midrst_id", 32'(ocpl_id), 32'd0);
    check("midrst_tag", 32'(ocpl_tag), 32'd0);
    check("midrst_stray", 32'(ostray_cnt), 32'd0);
    irst       = 1'b0;
    idone      = 1'b0;
    ireq_tag   = 16'h4321;
    do_job(0, 2);

    // Stray done pulses while idle saturate the counter.
    ireq_valid = '0;
    bad_start  = 1'b0;
    bad_cpl    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      idone = 1'b1;
      @(negedge iclk);
      idone = 1'b0;
      if (ostart) bad_start = 1'b1;
      if (ocpl_valid) bad_cpl = 1'b1;
      @(negedge iclk);
      if (ostart) bad_start = 1'b1;
      if (ocpl_valid) bad_cpl = 1'b1;
      if (i == 9) check("stray_10", 32'(ostray_cnt), 32'd10);
    end
    check("stray_sat", 32'(ostray_cnt), 32'd255);
    check("stray_no_start", 32'(bad_start), 32'd0);
    check("stray_no_cpl", 32'(bad_cpl), 32'd0);
    check("stray_idle", 32'(oidle), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
